// File: rtl/sha256_ctrl_pkg.sv
// sha256_ctrl_pkg
//   Shared constants for the SHA-256 round control sequencer: the FSM state
//   encoding (also exported as phase_code), per-block word and round counts,
//   and the round at which W switches to the schedule recurrence.
package sha256_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_LOAD   = 3'b001,
    S_ROUND  = 3'b010,
    S_UPDATE = 3'b011,
    S_DONE   = 3'b100
  } state_e;

  localparam int NUM_WORDS    = 16;
  localparam int NUM_ROUNDS   = 64;
  localparam int SCHED_THRESH = 16;

endpackage

// File: rtl/sha256_round_counter.sv
// sha256_round_counter
//   Up-counter with synchronous clear and enable plus a terminal-count flag.
//   Shared by the message word index (4 bits, terminal 15) and the round
//   index (6 bits, terminal 63). Wraps naturally past the terminal value.
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-high reset
//   clr_i         - clear to zero (wins over en_i)
//   en_i          - increment
//   cnt_o         - current count
//   tc_o          - count equals TERM
module sha256_round_counter #(
  parameter int               WIDTH = 6,
  parameter logic [WIDTH-1:0] TERM  = '1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (en_i)  cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == TERM);

endmodule

// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl
//   Control sequencer for the SHA-256 compression datapath. Per 512-bit block
//   it reads 16 message words, runs 64 rounds, then one hash-update cycle;
//   after the last block it pulses done for one cycle.
// Ports:
//   clock, reset   - rising-edge clock, synchronous active-high reset
//   start          - request, only looked at in IDLE
//   num_blocks     - block count, latched with start (0 = ignore request)
//   read_en        - message-memory read strobe (LOAD)
//   read_addr      - {block_idx, word_idx}, zero outside LOAD
//   h_init         - load H0..H7, first LOAD cycle of block 0
//   round_idx      - round 0..63, zero outside ROUND
//   w_sel          - 1 when W comes from the schedule recurrence
//   phase_code     - raw state encoding for the downstream pipeline register
//   busy           - not IDLE
//   done           - one-cycle completion pulse
// All outputs decode registered state only; no input-to-output paths.
module sha256_round_ctrl
  import sha256_ctrl_pkg::*;
#(
  parameter int BLOCK_AW = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [BLOCK_AW-1:0] num_blocks,
  output logic                read_en,
  output logic [BLOCK_AW+3:0] read_addr,
  output logic                h_init,
  output logic [5:0]          round_idx,
  output logic                w_sel,
  output logic [2:0]          phase_code,
  output logic                busy,
  output logic                done
);

  state_e              state_q, state_d;
  logic [BLOCK_AW-1:0] nblk_q, nblk_d;
  logic [BLOCK_AW-1:0] blk_q, blk_d;
  logic [BLOCK_AW:0]   blk_nxt;

  logic       word_clr, word_en, word_tc;
  logic [3:0] word_cnt;
  logic       rnd_clr, rnd_en, rnd_tc;
  logic [5:0] rnd_cnt;

  sha256_round_counter #(.WIDTH(4), .TERM(4'(NUM_WORDS - 1))) u_word_cnt (
    .clock (clock),
    .reset (reset),
    .clr_i (word_clr),
    .en_i  (word_en),
    .cnt_o (word_cnt),
    .tc_o  (word_tc)
  );

  sha256_round_counter #(.WIDTH(6), .TERM(6'(NUM_ROUNDS - 1))) u_rnd_cnt (
    .clock (clock),
    .reset (reset),
    .clr_i (rnd_clr),
    .en_i  (rnd_en),
    .cnt_o (rnd_cnt),
    .tc_o  (rnd_tc)
  );

  // One extra bit so block_idx+1 cannot wrap before the unsigned compare.
  assign blk_nxt = {1'b0, blk_q} + (BLOCK_AW+1)'(1);

  always_comb begin
    state_d  = state_q;
    nblk_d   = nblk_q;
    blk_d    = blk_q;
    word_clr = 1'b0;
    word_en  = 1'b0;
    rnd_clr  = 1'b0;
    rnd_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && (num_blocks != '0)) begin
          nblk_d   = num_blocks;
          blk_d    = '0;
          word_clr = 1'b1;
          rnd_clr  = 1'b1;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        // word_idx wraps 15 -> 0 on its own when leaving LOAD
        word_en = 1'b1;
        if (word_tc) begin
          rnd_clr = 1'b1;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        rnd_en = 1'b1;
        if (rnd_tc) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        word_clr = 1'b1;
        if (blk_nxt < {1'b0, nblk_q}) begin
          blk_d   = blk_nxt[BLOCK_AW-1:0];
          state_d = S_LOAD;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;   // illegal codes 101..111
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      nblk_q  <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      nblk_q  <= nblk_d;
      blk_q   <= blk_d;
    end
  end

  assign read_en    = (state_q == S_LOAD);
  assign read_addr  = read_en ? {blk_q, word_cnt} : '0;
  assign h_init     = read_en && (blk_q == '0) && (word_cnt == '0);
  assign round_idx  = (state_q == S_ROUND) ? rnd_cnt : '0;
  assign w_sel      = (state_q == S_ROUND) && (rnd_cnt >= 6'(SCHED_THRESH));
  assign phase_code = state_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// tb_sha256_round_ctrl
//   Self-checking bench: every cycle the DUT outputs are compared with a
//   reference model that derives them from "cycles since accept" arithmetic
//   (81 cycles per block, +1 for DONE). A table of block counts checks done
//   cycle / h_init / read counts, and hand sequences cover reset, ignored
//   requests, start held through DONE, mid-run reset and the phase trace.
module tb_sha256_round_ctrl;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] num_blocks;
  logic          read_en;
  logic [AW+3:0] read_addr;
  logic          h_init;
  logic [5:0]    round_idx;
  logic          w_sel;
  logic [2:0]    phase_code;
  logic          busy;
  logic          done;

  always #5 clock = ~clock;

  sha256_round_ctrl #(.BLOCK_AW(AW)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .num_blocks (num_blocks),
    .read_en    (read_en),
    .read_addr  (read_addr),
    .h_init     (h_init),
    .round_idx  (round_idx),
    .w_sel      (w_sel),
    .phase_code (phase_code),
    .busy       (busy),
    .done       (done)
  );

  // Stand-in for the downstream 3-bit pipeline register.
  logic [2:0] dreg;
  always @(posedge clock) dreg <= phase_code;

  typedef struct packed {
    logic          read_en;
    logic [AW+3:0] read_addr;
    logic          h_init;
    logic [5:0]    round_idx;
    logic          w_sel;
    logic [2:0]    phase;
    logic          busy;
    logic          done;
  } outs_t;

  outs_t act_o, exp_o;
  assign act_o = {read_en, read_addr, h_init, round_idx, w_sel, phase_code, busy, done};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: active run, cycle number within run (1-based), blocks.
  bit         m_act = 1'b0;
  int         m_t   = 0;
  int         m_n   = 0;
  bit         chk_en = 1'b0;
  bit         have_prev = 1'b0;
  logic [2:0] prev_phase;

  function automatic outs_t model_outs(bit a, int t, int n);
    outs_t o = '0;
    int b, r;
    if (!a) return o;
    o.busy = 1'b1;
    if (t == 81 * n + 1) begin
      o.phase = 3'd4;
      o.done  = 1'b1;
      return o;
    end
    b = (t - 1) / 81;
    r = (t - 1) % 81;
    if (r < 16) begin
      o.phase     = 3'd1;
      o.read_en   = 1'b1;
      o.read_addr = (AW+4)'(b * 16 + r);
      o.h_init    = (b == 0) && (r == 0);
    end else if (r < 80) begin
      o.phase     = 3'd2;
      o.round_idx = 6'(r - 16);
      o.w_sel     = (r - 16) >= 16;
    end else begin
      o.phase = 3'd3;
    end
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Advance one clock: update the model from the inputs the DUT sampled,
  // then compare all outputs 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    if (reset) m_act = 1'b0;
    else if (!m_act) begin
      if (start && (num_blocks != '0)) begin
        m_act = 1'b1;
        m_t   = 1;
        m_n   = int'(num_blocks);
      end
    end else if (m_t >= 81 * m_n + 1) m_act = 1'b0;
    else m_t++;
    #1;
    if (chk_en) begin
      exp_o = model_outs(m_act, m_t, m_n);
      n_tests++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL model_cycle: got %h, want %h (t=%0t)", act_o, exp_o, $time);
      end
      if (have_prev) chk("downstream_reg", 32'(dreg), 32'(prev_phase));
      prev_phase = exp_o.phase;
      have_prev  = 1'b1;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      if (!busy) return;
      tick();
    end
    n_tests++;
    n_fail++;
    $display("FAIL wait_idle_timeout: busy still %0b, want 0", busy);
  endtask

  // Run one request; start is re-pulsed (num_blocks=5) in cycles [nlo,nhi].
  task automatic run_seq(input int nb, input int nlo, input int nhi,
                         output int dcyc, output int hi, output int rd);
    dcyc = 0; hi = 0; rd = 0;
    start = 1'b1;
    num_blocks = AW'(nb);
    tick();
    start = 1'b0;
    for (int c = 1; c <= 1400; c++) begin
      if (done && dcyc == 0) dcyc = c;
      if (h_init)  hi++;
      if (read_en) rd++;
      if (!busy) begin
        start = 1'b0;
        return;
      end
      if (c >= nlo && c <= nhi) begin
        start = 1'b1;
        num_blocks = AW'(5);
      end else start = 1'b0;
      tick();
    end
    start = 1'b0;
    n_tests++;
    n_fail++;
    $display("FAIL run_seq_timeout: busy still %0b after 1400 cycles, want 0", busy);
  endtask

  typedef struct {
    int nb;
    int exp_done;
    int exp_hinit;
    int exp_reads;
  } vec_t;

  initial begin
    vec_t       vecs[5];
    int         dc, hi, rd, cnt;
    logic [2:0] ph[85];
    logic [2:0] dr[85];
    logic [2:0] ep[85];

    vecs[0] = '{1, 82, 1, 16};
    vecs[1] = '{2, 163, 1, 32};
    vecs[2] = '{3, 244, 1, 48};
    vecs[3] = '{15, 1216, 1, 240};
    vecs[4] = '{0, 0, 0, 0};

    // Reset: 3 cycles, then idle with start low.
    reset = 1'b1;
    start = 1'b0;
    num_blocks = '0;
    repeat (3) tick();
    chk("reset_outputs", 32'(act_o), 32'(0));
    chk("reset_phase", 32'(phase_code), 32'(0));
    chk_en = 1'b1;
    reset  = 1'b0;
    repeat (4) tick();
    chk("idle_busy", 32'(busy), 32'(0));

    // Table: done cycle, h_init pulses and read strobes per block count.
    foreach (vecs[i]) begin
      run_seq(vecs[i].nb, 0, -1, dc, hi, rd);
      chk($sformatf("tbl%0d_done_cycle", vecs[i].nb), 32'(dc), 32'(vecs[i].exp_done));
      chk($sformatf("tbl%0d_hinit", vecs[i].nb), 32'(hi), 32'(vecs[i].exp_hinit));
      chk($sformatf("tbl%0d_reads", vecs[i].nb), 32'(rd), 32'(vecs[i].exp_reads));
      tick();
    end

    // Zero-block request keeps IDLE.
    start = 1'b1;
    num_blocks = '0;
    repeat (3) tick();
    start = 1'b0;
    chk("zero_req_busy", 32'(busy), 32'(0));

    // Start pulses during ROUND of a 2-block run change nothing.
    run_seq(2, 20, 30, dc, hi, rd);
    chk("round_noise_done", 32'(dc), 32'(163));
    tick();

    // Start held high through DONE: ignored in DONE, taken in following IDLE.
    start = 1'b1;
    num_blocks = AW'(1);
    tick();
    for (int c = 2; c <= 82; c++) tick();
    chk("hold_done_c82", 32'(done), 32'(1));
    tick();
    chk("hold_idle_c83", 32'(busy), 32'(0));
    tick();
    chk("hold_reaccept_phase", 32'(phase_code), 32'(1));
    chk("hold_reaccept_hinit", 32'(h_init), 32'(1));
    start = 1'b0;
    wait_idle();

    // Reset at cycle 40 (round 23).
    start = 1'b1;
    num_blocks = AW'(1);
    tick();
    start = 1'b0;
    for (int c = 2; c <= 40; c++) tick();
    chk("mid_round_idx", 32'(round_idx), 32'(23));
    reset = 1'b1;
    tick();
    chk("mid_reset_outputs", 32'(act_o), 32'(0));
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (done) cnt++;
      tick();
    end
    chk("mid_reset_no_done", 32'(cnt), 32'(0));
    run_seq(1, 0, -1, dc, hi, rd);
    chk("after_reset_done", 32'(dc), 32'(82));
    tick();

    // Phase trace over one block, and its one-cycle-delayed copy.
    for (int c = 0; c < 85; c++)
      ep[c] = (c >= 1 && c <= 16) ? 3'd1 : (c >= 17 && c <= 80) ? 3'd2 :
              (c == 81) ? 3'd3 : (c == 82) ? 3'd4 : 3'd0;
    start = 1'b1;
    num_blocks = AW'(1);
    tick();
    start = 1'b0;
    for (int c = 1; c <= 84; c++) begin
      ph[c] = phase_code;
      dr[c] = dreg;
      if (c < 84) tick();
    end
    cnt = 0;
    for (int c = 1; c <= 83; c++) if (ph[c] !== ep[c]) cnt++;
    chk("phase_trace_mismatches", 32'(cnt), 32'(0));
    cnt = 0;
    for (int c = 2; c <= 84; c++) if (dr[c] !== ep[c-1]) cnt++;
    chk("dreg_trace_mismatches", 32'(cnt), 32'(0));

    // Random traffic, including stray resets, against the model.
    for (int i = 0; i < 3000; i++) begin
      start      = ($urandom_range(0, 9) == 0);
      num_blocks = AW'($urandom_range(0, 4));
      reset      = ($urandom_range(0, 599) == 0);
      tick();
    end
    reset = 1'b0;
    start = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_round_ctrl.md
# sha256_round_ctrl

Control sequencer for the SHA-256 compression datapath. It accepts a start request and a block count, then sequences the 16-word message load, the 64 compression rounds and the hash update for each 512-bit block. It drives the message-memory read port, the round index and the schedule-select line. Its 3-bit `phase_code` output feeds directly into the downstream 3-bit pipeline register (`registerIO3`), which re-times it for the datapath.

## Interface
- `BLOCK_AW`, default 4: block-index width; up to 2^BLOCK_AW − 1 blocks per request.
- `clock`  in  1  — clock; all logic on the rising edge.
- `reset`  in  1  — reset; synchronous, active-high.
- `start`  in  1  — request; sampled only in IDLE.
- `num_blocks`  in  BLOCK_AW  — number of blocks; sampled with `start`.
- `read_en`  out  1  — message-memory read strobe.
- `read_addr`  out  BLOCK_AW+4  — concatenation {block_idx, word_idx}.
- `h_init`  out  1  — one-cycle pulse: load initial hash constants H0..H7.
- `round_idx`  out  6  — current round, 0..63; valid in ROUND.
- `w_sel`  out  1  — 0: W from loaded words; 1: W from schedule recurrence.
- `phase_code`  out  3  — state encoding, to downstream register.
- `busy`  out  1  — high in every state except IDLE.
- `done`  out  1  — one-cycle completion pulse.

## Operation
- States and encodings (`phase_code`): IDLE=000, LOAD=001, ROUND=010, UPDATE=011, DONE=100. Codes 101–111 are illegal; the FSM recovers to IDLE on the next edge.
- **IDLE**
  - `start`=1 with `num_blocks`≠0 latches `num_blocks`, clears block_idx and word_idx, and moves to LOAD.
  - `start` with `num_blocks`=0 is ignored; the FSM stays in IDLE.
- **LOAD**: 16 cycles.
  - `read_en`=1 and `read_addr`={block_idx, word_idx}; word_idx steps 0..15.
  - `h_init`=1 in the first LOAD cycle of block 0 only.
  - After word_idx=15, moves to ROUND with round_idx=0.
- **ROUND**: 64 cycles.
  - round_idx steps 0..63.
  - `w_sel` = (round_idx ≥ 16).
  - After round 63, moves to UPDATE.
- **UPDATE**: 1 cycle (datapath adds working variables into H).
  - If block_idx+1 < latched count: block_idx increments, word_idx clears, go to LOAD.
  - Otherwise go to DONE.
- **DONE**: 1 cycle with `done`=1, then IDLE.
- `start` is ignored while `busy`=1; requests are not queued.
- Counters:
  - word_idx is 4 bits and wraps naturally.
  - round_idx is 6 bits.
  - block_idx is BLOCK_AW bits; comparisons are unsigned.

## Timing
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.
- Reset: state=IDLE. Every output is 0, including `phase_code`=000 and `read_addr`=0.
- Reset asserted mid-operation: IDLE on the next edge. No `done` pulse; counters cleared.
- Single block, `start` sampled at edge 0:
  - LOAD in cycles 1–16.
  - ROUND in cycles 17–80.
  - UPDATE in cycle 81.
  - DONE in cycle 82.
  - IDLE in cycle 83.
- N blocks: `done` in cycle 1 + 81·N.
- `phase_code` reaches the datapath one cycle later through the downstream register. The datapath aligns its round logic to that delayed copy.
- `start` high in the DONE cycle is ignored. It is accepted if still high in the following IDLE cycle.

## Structure
- Package `sha256_ctrl_pkg` holds:
  - state encoding constants (S_IDLE..S_DONE, 3 bits);
  - NUM_WORDS=16, NUM_ROUNDS=64;
  - the schedule-switch threshold 16.
- Optional sub-module `sha256_round_counter`: a 6-bit counter with clear/enable and a terminal-count flag. It is used for both word_idx (compare at 15) and round_idx (compare at 63).
- The FSM and address concatenation live in the top module.

## Test plan
- **Reset:** assert reset 3 cycles, release. All outputs are 0, `phase_code`=000; `busy` stays 0 with `start`=0.
- **Single block:** `start`=1, `num_blocks`=1 at cycle 0.
  - `read_addr` 0x00..0x0F in cycles 1–16, `h_init` in cycle 1.
  - `w_sel` rises at round_idx=16 (cycle 33).
  - `done` in cycle 82 only.
- **Three blocks:** `num_blocks`=3.
  - Second LOAD issues addresses 0x10..0x1F; third issues 0x20..0x2F.
  - `h_init` pulses once.
  - `done` in cycle 244.
- **Ignored requests:** `start` with `num_blocks`=0 keeps IDLE, `busy`=0. `start` pulses during ROUND do not alter the sequence or the `done` cycle.
- **Reset mid-run:** reset at cycle 40 (ROUND, round_idx=23). Next cycle IDLE, all outputs 0, no `done`; a new start runs a full 82-cycle sequence.
- **Phase trace:** the `phase_code` sequence over one block is 001×16, 010×64, 011, 100, 000. The downstream register output matches it shifted by one cycle.
